// File: rtl/z3_slave_ctrl_pkg.sv
// Shared constants, state encoding and output bundle for the Zorro III slave controller.
package z3_slave_ctrl_pkg;

   localparam int unsigned CTR_W        = 8;
   localparam int unsigned ROM_WAIT_DEF = 3;
   localparam int unsigned TIMEOUT_DEF  = 255;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_ACK  = 2'd3;

   typedef struct packed {
      logic slave_n;
      logic slave_cycle;
      logic scsi_cycle;
      logic rom_cycle;
      logic doe;
      logic dtack_n;
      logic berr_n;
   } outs_t;

   localparam outs_t OUTS_RST = '{slave_n: 1'b1, slave_cycle: 1'b0, scsi_cycle: 1'b0,
                                  rom_cycle: 1'b0, doe: 1'b0, dtack_n: 1'b1, berr_n: 1'b1};

   // Any active (low) data strobe marks the start of the data phase.
   function automatic logic ds_active(input logic [3:0] ds_n);
      return ~&ds_n;
   endfunction

endpackage

// File: rtl/z3_slave_ctrl_if.sv
// Zorro III slave-side bus bundle between the CPU-facing decode and the slave controller.
interface z3_slave_ctrl_if;

   logic       FCS_n;
   logic       MATCH;
   logic       SCSI_SEL;
   logic       READ;
   logic [3:0] DS_n;
   logic       SCSI_STERM_n;
   logic       SLAVE_n;
   logic       slave_cycle;
   logic       scsi_cycle;
   logic       rom_cycle;
   logic       DOE;
   logic       DTACK_n;
   logic       BERR_n;

   modport slave (
      input  FCS_n, MATCH, SCSI_SEL, READ, DS_n, SCSI_STERM_n,
      output SLAVE_n, slave_cycle, scsi_cycle, rom_cycle, DOE, DTACK_n, BERR_n
   );

   modport master (
      output FCS_n, MATCH, SCSI_SEL, READ, DS_n, SCSI_STERM_n,
      input  SLAVE_n, slave_cycle, scsi_cycle, rom_cycle, DOE, DTACK_n, BERR_n
   );

endinterface

// File: rtl/z3_slave_ctrl_wait_ctr.sv
// Shared down-counter for the ROM wait and the SCSI timeout; load wins over decrement.
module slave_wait_ctr #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero_c
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/z3_slave_ctrl.sv
// Zorro III slave-cycle controller for the A4092: qualifies accesses, times ROM/SCSI data phases.
// Optional SLAVE_TIMEOUT_EN adds a BERR_n-terminating timeout on SCSI cycles lacking STERM.
module z3_slave_ctrl
   import z3_slave_ctrl_pkg::*;
#(
   parameter int unsigned ROM_WAIT = ROM_WAIT_DEF
`ifdef SLAVE_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
   input  logic            CLK,
   input  logic            IORST_n,
   z3_slave_ctrl_if.slave  bus
);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_sel;
   logic             w_sel_nxt;
   outs_t            r_outs;
   outs_t            w_outs_nxt;
   logic             w_ctr_load;
   logic [CTR_W-1:0] w_ctr_val;
   logic             w_ctr_en;
   logic             w_ctr_zero;
   logic             w_timeout;

   slave_wait_ctr #(.W(CTR_W)) u_wait_ctr (
      .clk        (CLK),
      .rst_n      (IORST_n),
      .i_load     (w_ctr_load),
      .i_load_val (w_ctr_val),
      .i_en       (w_ctr_en),
      .o_zero_c   (w_ctr_zero)
   );

   always_ff @(posedge CLK) begin
      if (!IORST_n) begin
         r_state <= ST_IDLE;
         r_sel   <= 1'b0;
         r_outs  <= OUTS_RST;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_outs  <= w_outs_nxt;
      end
   end

   // Next state plus next registered outputs, derived from the state being entered.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_ctr_load  = 1'b0;
      w_ctr_val   = '0;
      w_ctr_en    = 1'b0;
      w_timeout   = 1'b0;
      w_outs_nxt  = OUTS_RST;

      case (r_state)
         ST_IDLE: begin
            if (!bus.FCS_n && bus.MATCH) begin
               w_state_nxt = ST_ADDR;
               w_sel_nxt   = bus.SCSI_SEL;
            end
         end
         ST_ADDR: begin
            if (bus.FCS_n) begin
               w_state_nxt = ST_IDLE;
            end else if (ds_active(bus.DS_n)) begin
               w_state_nxt = ST_DATA;
               w_ctr_load  = 1'b1;
               if (!r_sel) begin
                  w_ctr_val = CTR_W'(ROM_WAIT - 1);
               end
`ifdef SLAVE_TIMEOUT_EN
               else begin
                  w_ctr_val = CTR_W'(TIMEOUT_CYCLES - 1);
               end
`endif
            end
         end
         ST_DATA: begin
            // Abort beats a same-cycle STERM or counter expiry.
            if (bus.FCS_n) begin
               w_state_nxt = ST_IDLE;
            end else if (r_sel) begin
               if (!bus.SCSI_STERM_n) begin
                  w_state_nxt = ST_ACK;
               end
`ifdef SLAVE_TIMEOUT_EN
               else if (w_ctr_zero) begin
                  w_state_nxt = ST_ACK;
                  w_timeout   = 1'b1;
               end else begin
                  w_ctr_en = 1'b1;
               end
`endif
            end else if (w_ctr_zero) begin
               w_state_nxt = ST_ACK;
            end else begin
               w_ctr_en = 1'b1;
            end
         end
         ST_ACK: begin
            if (bus.FCS_n) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_state_nxt != ST_IDLE) begin
         w_outs_nxt.slave_n     = 1'b0;
         w_outs_nxt.slave_cycle = 1'b1;
      end
      if ((w_state_nxt == ST_DATA) || (w_state_nxt == ST_ACK)) begin
         w_outs_nxt.doe        = 1'b1;
         w_outs_nxt.scsi_cycle = w_sel_nxt;
         w_outs_nxt.rom_cycle  = ~w_sel_nxt;
      end
      // BERR_n is decided on ACK entry and held until the cycle ends.
      if (w_state_nxt == ST_ACK) begin
         w_outs_nxt.dtack_n = 1'b0;
         w_outs_nxt.berr_n  = (r_state == ST_ACK) ? r_outs.berr_n : ~w_timeout;
      end
   end

   assign bus.SLAVE_n     = r_outs.slave_n;
   assign bus.slave_cycle = r_outs.slave_cycle;
   assign bus.scsi_cycle  = r_outs.scsi_cycle;
   assign bus.rom_cycle   = r_outs.rom_cycle;
   assign bus.DOE         = r_outs.doe;
   assign bus.DTACK_n     = r_outs.dtack_n;
   assign bus.BERR_n      = r_outs.berr_n;

endmodule

// File: tb/tb_z3_slave_ctrl.sv
// Randomized bench for z3_slave_ctrl; expectations come from per-access edge arithmetic.
module tb_z3_slave_ctrl;

   localparam int unsigned ROM_WAIT = 3;
`ifdef SLAVE_TIMEOUT_EN
   localparam int unsigned TIMEOUT_CYCLES = 8;
`endif
   localparam int NEVER = 1000000;
   localparam logic [6:0] IDLE_OUTS = 7'b1000011;

   logic CLK     = 1'b0;
   logic IORST_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   z3_slave_ctrl_if bus();

   z3_slave_ctrl #(
      .ROM_WAIT(ROM_WAIT)
`ifdef SLAVE_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
   ) dut (
      .CLK     (CLK),
      .IORST_n (IORST_n),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   wire [6:0] w_outs = {bus.SLAVE_n, bus.slave_cycle, bus.scsi_cycle, bus.rom_cycle,
                        bus.DOE, bus.DTACK_n, bus.BERR_n};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.FCS_n        = 1'b1;
      bus.MATCH        = 1'b0;
      bus.SCSI_SEL     = 1'b0;
      bus.READ         = 1'b0;
      bus.DS_n         = 4'hF;
      bus.SCSI_STERM_n = 1'b1;
   endtask

   // Edge 0: FCS_n falls. Edge d: first strobe. Edge t: STERM held low. Edge r: FCS_n rises.
   function automatic int ack_edge(input bit sel, input int d, input int t);
      int a;
      a = sel ? t : d + int'(ROM_WAIT);
`ifdef SLAVE_TIMEOUT_EN
      if (sel && (t > d + int'(TIMEOUT_CYCLES))) a = d + int'(TIMEOUT_CYCLES);
`endif
      return a;
   endfunction

   task automatic do_access(input bit match, input bit sel, input int d, input int t,
                            input int r, input string tag);
      int ack_e;
      bit to_berr;
      bit engaged, data, acked;
      ack_e   = ack_edge(sel, d, t);
      to_berr = sel && (ack_e != t) && (ack_e < NEVER);
      for (int e = 0; e <= r; e++) begin
         bus.FCS_n    = (e >= r);
         bus.MATCH    = (e == 0 || !match) ? match : 1'($urandom_range(0, 1));
         bus.SCSI_SEL = (e == 0) ? sel : 1'($urandom_range(0, 1));
         bus.READ     = 1'($urandom_range(0, 1));
         if (e < d)       bus.DS_n = 4'hF;
         else if (e == d) bus.DS_n = 4'($urandom_range(0, 14));
         else             bus.DS_n = 4'($urandom_range(0, 15));
         bus.SCSI_STERM_n = !((e >= t && e < r) || (e <= d && $urandom_range(0, 3) == 0));
         step();
         engaged = match && (e < r);
         data    = engaged && (e >= d);
         acked   = engaged && (e >= ack_e);
         check($sformatf("%s e%0d", tag, e), 32'(w_outs),
               32'({!engaged, engaged, data && sel, data && !sel, data, !acked,
                    !(acked && to_berr)}));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit sel, match;
      int d, t, a, r;

      idle_inputs();
      IORST_n = 1'b0;
      step();
      step();
      check("reset", 32'(w_outs), 32'(IDLE_OUTS));
      IORST_n = 1'b1;
      step();
      check("idle", 32'(w_outs), 32'(IDLE_OUTS));

      do_access(1'b1, 1'b1, 1, 5, 8, "scsi_rd");
      do_access(1'b1, 1'b0, 1, NEVER, 7, "rom_rd");
      do_access(1'b0, 1'b1, 1, 3, 10, "nomatch");

      do_access(1'b1, 1'b1, 1, NEVER, 4, "abort");
      for (int i = 0; i < 3; i++) begin
         bus.SCSI_STERM_n = 1'b0;
         step();
         check($sformatf("abort_sterm %0d", i), 32'(w_outs), 32'(IDLE_OUTS));
      end
      bus.SCSI_STERM_n = 1'b1;

      do_access(1'b1, 1'b1, 2, NEVER, 302, "noterm");

      repeat (60) begin
         sel   = 1'($urandom_range(0, 1));
         match = ($urandom_range(0, 9) != 0);
         d     = int'($urandom_range(1, 3));
         if (sel) t = ($urandom_range(0, 3) == 0) ? NEVER : d + int'($urandom_range(1, 6));
         else     t = NEVER;
         a = ack_edge(sel, d, t);
         if (a >= NEVER)                      r = d + int'($urandom_range(1, 10));
         else if ($urandom_range(0, 3) == 0)  r = int'($urandom_range(1, a));
         else                                 r = a + int'($urandom_range(1, 3));
         do_access(match, sel, d, t, r, "rnd");
         repeat ($urandom_range(0, 2)) begin
            idle_inputs();
            step();
            check("rnd_gap", 32'(w_outs), 32'(IDLE_OUTS));
         end
      end

      idle_inputs();
      bus.FCS_n = 1'b0;
      bus.MATCH = 1'b1;
      step();
      bus.DS_n = 4'h0;
      repeat (4) step();
      check("pre_rst_ack", 32'(w_outs), 32'(7'b0101101));
      IORST_n = 1'b0;
      step();
      check("rst_in_ack", 32'(w_outs), 32'(IDLE_OUTS));
      IORST_n   = 1'b1;
      bus.FCS_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post_rst %0d", i), 32'(w_outs), 32'(IDLE_OUTS));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
